// File: rtl/encoder_8to3_if.sv
// Bus between the producer of the input vector and the leading-ones encoder.
// The producer drives r; the encoder returns the registered count on Y.
interface encoder_8to3_if #(
    parameter int WIDTH = 8,
    parameter int OUT_W = 4
);
    logic [WIDTH-1:0] r;
    logic [OUT_W-1:0] Y;

    modport master (output r, input Y);
    modport slave  (input r, output Y);
endinterface

// File: rtl/encoder_8to3.sv
// Registered leading-ones encoder: counts the 1 bits from the MSB of r down to
// the first 0, and presents that count (0..WIDTH) on Y one clock later.
module encoder_8to3 #(
    parameter int WIDTH = 8,
    parameter int OUT_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    encoder_8to3_if.slave  bus
);

    logic [OUT_W-1:0] count;
    logic             run;

    // NOTE: count and run get defaults before the loop, so every path assigns
    // them and no latch is inferred; blocking '=' is correct inside always_comb.
    always_comb begin
        count = '0;
        run   = 1'b1;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (run && bus.r[i]) begin
                count = count + OUT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    // NOTE: registered state uses non-blocking '<=' so every flop samples the
    // values that were present before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.Y <= '0;
        end else begin
            bus.Y <= count;
        end
    end

endmodule

// File: tb/tb_encoder_8to3.sv
// Self-checking bench for encoder_8to3: directed cases, an exhaustive sweep and
// random vectors, checked against a mask-based leading-ones model every cycle.
module tb_encoder_8to3;

    logic clk = 1'b0;
    logic rst;
    logic chk_en = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_y = 0;

    encoder_8to3_if #(.WIDTH(8), .OUT_W(4)) bus ();

    encoder_8to3 #(.WIDTH(8), .OUT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Largest k such that the top k bits of v are all ones.
    function automatic int lead_ones(input logic [7:0] v);
        int val;
        int mask;
        val = int'(v);
        for (int k = 8; k >= 0; k--) begin
            mask = ((1 << k) - 1) << (8 - k);
            if ((val & mask) == mask) return k;
        end
        return 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference register: follows the rules for rst and the sampling edge.
    always @(posedge clk or posedge rst) begin
        if (rst) exp_y = 0;
        else     exp_y = lead_ones(bus.r);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_compare", int'(bus.Y), exp_y);
            check("y_range", int'(bus.Y <= 4'd8), 1);
        end
    end

    // Drive v just after an edge, wait for the next edge, return at edge+1.
    task automatic apply(input logic [7:0] v);
        bus.r = v;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] seq_r [8] = '{8'b10010110, 8'b11010110, 8'b11100110, 8'b11110110,
                              8'b11111010, 8'b11111100, 8'b11111110, 8'b11111111};
    logic [7:0] dc_r  [4] = '{8'b11000000, 8'b11011111, 8'b00000000, 8'b01111111};
    int         dc_y  [4] = '{2, 2, 0, 0};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b0;
        bus.r = 8'b01010110;
        #1 rst = 1'b1;
        #1 chk_en = 1'b1;
        #1 check("reset_async", int'(bus.Y), 0);

        check("model_ff", lead_ones(8'hFF), 8);
        check("model_fe", lead_ones(8'hFE), 7);
        check("model_7f", lead_ones(8'h7F), 0);
        check("model_c0", lead_ones(8'hC0), 2);

        repeat (2) @(posedge clk);
        #1 check("reset_hold", int'(bus.Y), 0);
        rst = 1'b0;
        @(posedge clk);
        #1 check("first_after_reset", int'(bus.Y), 0);

        for (int i = 0; i < 8; i++) begin
            apply(seq_r[i]);
            check("sequence", int'(bus.Y), i + 1);
        end

        for (int i = 0; i < 4; i++) begin
            apply(dc_r[i]);
            check("dont_care", int'(bus.Y), dc_y[i]);
        end

        apply(8'hFF);
        check("latency_pre", int'(bus.Y), 8);
        #2 bus.r = 8'h00;
        #1 check("latency_hold", int'(bus.Y), 8);
        @(posedge clk);
        #1 check("latency_load", int'(bus.Y), 0);

        apply(8'hFF);
        check("async_pre", int'(bus.Y), 8);
        #2 rst = 1'b1;
        #1 check("async_clear", int'(bus.Y), 0);
        repeat (2) @(posedge clk);
        #1 check("async_hold", int'(bus.Y), 0);
        bus.r = 8'b11100000;
        rst   = 1'b0;
        @(posedge clk);
        #1 check("async_release", int'(bus.Y), 3);

        for (int i = 0; i < 256; i++) begin
            apply(8'(i));
            check("exhaustive", int'(bus.Y), lead_ones(8'(i)));
        end

        for (int i = 0; i < 200; i++) begin
            logic [7:0] v;
            v = 8'($urandom_range(0, 255));
            apply(v);
            check("random", int'(bus.Y), lead_ones(v));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
